bcd_scan_ctrl: RTL and testbench

Sequential controller for the binary-to-7-segment display path. It converts an N-bit binary value to packed BCD with an iterative shift-add-3 (double-dabble) engine, using a start/busy/done handshake. It then time-multiplexes the BCD digits onto one shared `decoder_7_seg` through an active-low digit-enable scan. It sits between the value source (switches or counter) and the board's 4-digit multiplexed display, replacing per-digit combinational `/` and `%` logic.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_scan_ctrl_digit_scan.sv | 46 ++++
 rtl/bcd_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD conversion and scan path
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'h9;

  // Constant function for elaboration-time decimal limits; 64 bits covers 10^8 easily.
  function automatic logic [63:0] pow10(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_digit_scan.sv
// rtl/bcd_scan_ctrl_digit_scan.sv - free-running digit multiplexer for the shared 7-segment decoder
module digit_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  output bcd_digit_t            digit_bcd,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_d;
  logic          pre_wrap;

  always_comb begin
    pre_wrap = (pre == PW'(SCAN_DIV - 1));
    idx_d    = idx;
    if (pre_wrap) begin
      idx_d = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Outputs are registered from the next index so nibble and enable move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      idx       <= '0;
      digit_bcd <= '0;
      digit_sel <= ~DIGITS'(1);
    end else begin
      pre       <= pre_wrap ? '0 : pre + PW'(1);
      idx       <= idx_d;
      digit_bcd <= bcd[4*idx_d +: 4];
      digit_sel <= ~(DIGITS'(1) << idx_d);
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - iterative binary-to-BCD converter with multiplexed digit scan output
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int N        = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          num_b,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output bcd_digit_t            digit_bcd,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int BW    = 4 * DIGITS;
  localparam int CW    = max_int(N, BW) + 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [63:0]   LIMIT64 = pow10(DIGITS);
  localparam logic [CW-1:0] LIMIT   = LIMIT64[CW-1:0];
  // When N bits cannot reach 10^DIGITS the overflow flag is tied off.
  localparam bit CAN_OVF = (N >= 63) || (((64'd1 << N) - 64'd1) >= LIMIT64);

  state_t           state, state_d;
  logic [N-1:0]     bin;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_shift;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             ovf_next;
  logic             ovf_cmp;
  logic             busy_d;
  logic             done_d;

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (work[4*k +: 4] >= 4'd5) ? work[4*k +: 4] + 4'd3 : work[4*k +: 4];
    end
  end

  assign work_shift = {adj[BW-2:0], bin[N-1]};
  assign last_bit   = (cnt == CNT_W'(N - 1));
  assign ovf_cmp    = CAN_OVF && ({{(CW-N){1'b0}}, num_b} >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == LOAD);
  end

  // The result is committed on the edge entering LOAD so it is visible alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin      <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin      <= num_b;
            work     <= '0;
            cnt      <= '0;
            ovf_next <= ovf_cmp;
          end
        end
        SHIFT: begin
          bin  <= bin << 1;
          work <= work_shift;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            bcd_out <= ovf_next ? {DIGITS{BCD_NINE}} : work_shift;
            ovf     <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  digit_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bcd_out),
    .digit_bcd (digit_bcd),
    .digit_sel (digit_sel)
  );

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - scoreboard bench for bcd_scan_ctrl with N=10 and N=14 instances
module tb_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s10, s14;
  logic [9:0]  n10;
  logic [13:0] n14;
  logic        busy10, done10, ovf10, busy14, done14, ovf14;
  logic [15:0] b10, b14;
  logic [3:0]  db10, db14, sel10, sel14;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.N(10), .DIGITS(4), .SCAN_DIV(4)) u10 (
    .clk(clk), .rst_n(rst_n), .start(s10), .num_b(n10), .busy(busy10), .done(done10),
    .ovf(ovf10), .bcd_out(b10), .digit_bcd(db10), .digit_sel(sel10));

  bcd_scan_ctrl #(.N(14), .DIGITS(4), .SCAN_DIV(4)) u14 (
    .clk(clk), .rst_n(rst_n), .start(s14), .num_b(n14), .busy(busy14), .done(done14),
    .ovf(ovf14), .bcd_out(b14), .digit_bcd(db14), .digit_sel(sel14));

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t q10[$];
  exp_t q14[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done10) begin
      if (q10.size() == 0) check("u10 unexpected done", 1, 0);
      else begin
        e = q10.pop_front();
        check("u10 bcd_out", b10, e.bcd);
        check("u10 ovf", ovf10, e.ovf);
        check("u10 done cycle", cyc, e.at);
      end
    end
    if (done14) begin
      if (q14.size() == 0) check("u14 unexpected done", 1, 0);
      else begin
        e = q14.pop_front();
        check("u14 bcd_out", b14, e.bcd);
        check("u14 ovf", ovf14, e.ovf);
        check("u14 done cycle", cyc, e.at);
      end
    end
  end

  initial begin
    int          rel;
    int          c;
    int          idx;
    logic [3:0]  exp_sel;
    logic [15:0] v;

    rst_n = 1'b0; s10 = 1'b0; s14 = 1'b0; n10 = '0; n14 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy10, 0);
    check("reset done", done10, 0);
    check("reset ovf", ovf10, 0);
    check("reset bcd_out", b10, 0);
    check("reset digit_sel", sel10, 4'b1110);
    check("reset digit_bcd", db10, 0);
    rst_n = 1'b1;
    rel = cyc;

    for (int k = 0; k < 17; k++) begin
      exp_sel = ~(4'b0001 << ((k / 4) % 4));
      check("idle digit_sel", sel10, exp_sel);
      check("idle digit_bcd", db10, 0);
      check("idle busy", busy10, 0);
      @(negedge clk);
    end

    // 1023 with busy window
    q10.push_back('{16'h1023, 1'b0, cyc + 11});
    s10 = 1'b1; n10 = 10'd1023;
    for (int j = 0; j <= 12; j++) begin
      check("busy window", busy10, (j >= 1 && j <= 11) ? 1 : 0);
      if (j == 1) s10 = 1'b0;
      @(negedge clk);
    end

    v = 16'h1023;
    for (int k = 0; k < 8; k++) begin
      idx = ((cyc - rel) / 4) % 4;
      exp_sel = ~(4'b0001 << idx);
      check("scan digit_bcd", db10, v[4*idx +: 4]);
      check("scan digit_sel", sel10, exp_sel);
      @(negedge clk);
    end

    // back-to-back with start held high
    c = cyc;
    q10.push_back('{16'h0000, 1'b0, c + 11});
    q10.push_back('{16'h0999, 1'b0, c + 23});
    q10.push_back('{16'h1000, 1'b0, c + 35});
    s10 = 1'b1; n10 = 10'd0;
    @(negedge clk);
    n10 = 10'd999;
    repeat (12) @(negedge clk);
    n10 = 10'd1000;
    repeat (12) @(negedge clk);
    s10 = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b queue drained", q10.size(), 0);

    // restart during SHIFT is ignored
    c = cyc;
    q10.push_back('{16'h1023, 1'b0, c + 11});
    s10 = 1'b1; n10 = 10'd1023;
    @(negedge clk);
    s10 = 1'b0;
    repeat (3) @(negedge clk);
    s10 = 1'b1; n10 = 10'd5;
    @(negedge clk);
    s10 = 1'b0;
    repeat (10) @(negedge clk);
    check("ignored start queue", q10.size(), 0);
    check("ignored start result", b10, 16'h1023);

    // N=14 overflow, then recovery
    c = cyc;
    q14.push_back('{16'h9999, 1'b1, c + 15});
    s14 = 1'b1; n14 = 14'd12345;
    @(negedge clk);
    s14 = 1'b0;
    repeat (15) @(negedge clk);
    q14.push_back('{16'h0042, 1'b0, cyc + 15});
    s14 = 1'b1; n14 = 14'd42;
    @(negedge clk);
    s14 = 1'b0;
    repeat (16) @(negedge clk);
    check("u14 queue drained", q14.size(), 0);
    check("u14 final bcd", b14, 16'h0042);
    check("u14 final ovf", ovf14, 0);

    // reset in the middle of a conversion
    q10.push_back('{16'h0777, 1'b0, cyc + 11});
    s10 = 1'b1; n10 = 10'd777;
    @(negedge clk);
    s10 = 1'b0;
    repeat (12) @(negedge clk);
    check("pre-abort queue", q10.size(), 0);
    s10 = 1'b1; n10 = 10'd123;
    @(negedge clk);
    s10 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-abort busy", busy10, 1);
    check("pre-abort bcd", b10, 16'h0777);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy10, 0);
    check("abort done", done10, 0);
    check("abort bcd_out", b10, 0);
    check("abort ovf", ovf10, 0);
    check("abort digit_sel", sel10, 4'b1110);
    check("abort digit_bcd", db10, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post-abort bcd_out", b10, 0);
    check("post-abort busy", busy10, 0);
    check("post-abort queue", q10.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
